// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache sequencing controller.
// Holds the controller state enum, the request operation enum and the
// width of the performance counters.
package cache_ctrl_pkg;

  localparam int PERF_CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    EVICT    = 3'd2,
    FILL     = 3'd3,
    WT_WRITE = 3'd4,
    RESPOND  = 3'd5
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } req_op_e;

endpackage

// File: rtl/cache_internal_if.sv
// Strobe/status bundle between the cache sequencing controller and the
// cache datapath.
//   controller modport: drives all datapath strobes, observes
//                       counter_done, valid_block_match, valid_dirty_bit.
//   datapath modport  : the mirror image.
interface cache_internal_if;

  logic count_read;
  logic count_write;
  logic count_hit;
  logic count_miss;
  logic process_lru_counters;
  logic perform_write;
  logic set_selected_dirty_bit;
  logic clear_selected_dirty_bit;
  logic clear_selected_valid_bit;
  logic set_hmem_block_address;
  logic use_victim_tag_for_hmem_block_address;
  logic reset_counter;
  logic decrement_counter;
  logic miss_recovery_mode;
  logic finish_new_line_install;

  logic counter_done;
  logic valid_block_match;
  logic valid_dirty_bit;

  modport controller (
    output count_read, count_write, count_hit, count_miss,
           process_lru_counters, perform_write,
           set_selected_dirty_bit, clear_selected_dirty_bit,
           clear_selected_valid_bit, set_hmem_block_address,
           use_victim_tag_for_hmem_block_address,
           reset_counter, decrement_counter,
           miss_recovery_mode, finish_new_line_install,
    input  counter_done, valid_block_match, valid_dirty_bit
  );

  modport datapath (
    input  count_read, count_write, count_hit, count_miss,
           process_lru_counters, perform_write,
           set_selected_dirty_bit, clear_selected_dirty_bit,
           clear_selected_valid_bit, set_hmem_block_address,
           use_victim_tag_for_hmem_block_address,
           reset_counter, decrement_counter,
           miss_recovery_mode, finish_new_line_install,
    output counter_done, valid_block_match, valid_dirty_bit
  );

endinterface

// File: rtl/cache_perf_counter.sv
// Saturating event counter with asynchronous active-low reset.
// Ports:
//   clk, reset_n : clock, async active-low reset (clears the count)
//   inc          : add one this cycle unless already at all-ones
//   count        : current value, holds at all-ones once reached
module cache_perf_counter
  import cache_ctrl_pkg::*;
#(
  parameter int WIDTH = PERF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_seq_controller.sv
// Cache sequencing controller: accepts CPU requests, decides hit/miss from
// datapath status, sequences victim write-back and line fill beats to
// higher memory, and replays the lookup after a fill.
// Optional feature macro: CACHE_CTRL_PERF_EN builds saturating hit/miss/
// evict counters; without it the counter ports are tied to zero.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   req_valid/req_ready     : CPU request handshake, req_we = write
//   resp_valid              : one-cycle completion pulse
//   hmem_req/hmem_we/ack    : higher-memory beat handshake
//   ctl                     : datapath strobes and status
//   hit/miss/evict_count    : performance counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request
// LOOKUP   | tag compare result sampled; hit/miss decision
// EVICT    | writing the dirty victim line out, one beat per ack
// FILL     | reading the requested line in, one beat per ack
// WT_WRITE | single write-through beat to higher memory
// RESPOND  | resp_valid high for one cycle
module cache_seq_controller
  import cache_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int WRITE_BACK = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  output logic                  resp_valid,
  output logic                  hmem_req,
  output logic                  hmem_we,
  input  logic                  hmem_ack,
  cache_internal_if.controller  ctl,
  output logic [PERF_CNT_W-1:0] hit_count,
  output logic [PERF_CNT_W-1:0] miss_count,
  output logic [PERF_CNT_W-1:0] evict_count
);

  localparam bit WB_MODE     = (WRITE_BACK != 0);
  // A one-word line finishes on its first beat regardless of the counter.
  localparam bit SINGLE_BEAT = (LINE_WORDS == 1);

  state_e  state;
  req_op_e op;
  logic    line_done;

  assign line_done = ctl.counter_done | SINGLE_BEAT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                                     <= IDLE;
      op                                        <= OP_READ;
      req_ready                                 <= 1'b1;
      resp_valid                                <= 1'b0;
      hmem_req                                  <= 1'b0;
      hmem_we                                   <= 1'b0;
      ctl.count_read                            <= 1'b0;
      ctl.count_write                           <= 1'b0;
      ctl.count_hit                             <= 1'b0;
      ctl.count_miss                            <= 1'b0;
      ctl.process_lru_counters                  <= 1'b0;
      ctl.perform_write                         <= 1'b0;
      ctl.set_selected_dirty_bit                <= 1'b0;
      ctl.clear_selected_dirty_bit              <= 1'b0;
      ctl.clear_selected_valid_bit              <= 1'b0;
      ctl.set_hmem_block_address                <= 1'b0;
      ctl.use_victim_tag_for_hmem_block_address <= 1'b0;
      ctl.reset_counter                         <= 1'b0;
      ctl.decrement_counter                     <= 1'b0;
      ctl.miss_recovery_mode                    <= 1'b0;
      ctl.finish_new_line_install               <= 1'b0;
    end else begin
      // single-cycle strobes default low; level outputs hold
      resp_valid                                <= 1'b0;
      ctl.count_read                            <= 1'b0;
      ctl.count_write                           <= 1'b0;
      ctl.count_hit                             <= 1'b0;
      ctl.count_miss                            <= 1'b0;
      ctl.process_lru_counters                  <= 1'b0;
      ctl.perform_write                         <= 1'b0;
      ctl.set_selected_dirty_bit                <= 1'b0;
      ctl.clear_selected_dirty_bit              <= 1'b0;
      ctl.clear_selected_valid_bit              <= 1'b0;
      ctl.set_hmem_block_address                <= 1'b0;
      ctl.use_victim_tag_for_hmem_block_address <= 1'b0;
      ctl.reset_counter                         <= 1'b0;
      ctl.decrement_counter                     <= 1'b0;
      ctl.finish_new_line_install               <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            op        <= req_we ? OP_WRITE : OP_READ;
            req_ready <= 1'b0;
            if (req_we) ctl.count_write <= 1'b1;
            else        ctl.count_read  <= 1'b1;
            state     <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (ctl.valid_block_match) begin
            ctl.count_hit            <= 1'b1;
            ctl.process_lru_counters <= 1'b1;
            if (op == OP_READ) begin
              resp_valid <= 1'b1;
              state      <= RESPOND;
            end else begin
              ctl.perform_write <= 1'b1;
              if (WB_MODE) begin
                ctl.set_selected_dirty_bit <= 1'b1;
                resp_valid                 <= 1'b1;
                state                      <= RESPOND;
              end else begin
                hmem_req <= 1'b1;
                hmem_we  <= 1'b1;
                state    <= WT_WRITE;
              end
            end
          end else begin
            ctl.count_miss <= 1'b1;
            if ((op == OP_WRITE) && !WB_MODE) begin
              // no-write-allocate: cache untouched, word goes straight out
              hmem_req <= 1'b1;
              hmem_we  <= 1'b1;
              state    <= WT_WRITE;
            end else begin
              ctl.set_hmem_block_address <= 1'b1;
              ctl.reset_counter          <= 1'b1;
              ctl.miss_recovery_mode     <= 1'b1;
              hmem_req                   <= 1'b1;
              if (WB_MODE && ctl.valid_dirty_bit) begin
                ctl.use_victim_tag_for_hmem_block_address <= 1'b1;
                hmem_we <= 1'b1;
                state   <= EVICT;
              end else begin
                ctl.clear_selected_valid_bit <= 1'b1;
                hmem_we <= 1'b0;
                state   <= FILL;
              end
            end
          end
        end

        EVICT: begin
          if (hmem_ack) begin
            ctl.decrement_counter <= 1'b1;
            if (line_done) begin
              // victim gone; retarget address to the requested tag and fill
              ctl.clear_selected_dirty_bit <= 1'b1;
              ctl.set_hmem_block_address   <= 1'b1;
              ctl.reset_counter            <= 1'b1;
              hmem_we                      <= 1'b0;
              state                        <= FILL;
            end
          end
        end

        FILL: begin
          if (hmem_ack) begin
            ctl.decrement_counter <= 1'b1;
            if (line_done) begin
              ctl.finish_new_line_install <= 1'b1;
              ctl.miss_recovery_mode      <= 1'b0;
              hmem_req                    <= 1'b0;
              state                       <= LOOKUP;
            end
          end
        end

        WT_WRITE: begin
          if (hmem_ack) begin
            hmem_req   <= 1'b0;
            hmem_we    <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESPOND;
          end
        end

        RESPOND: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          req_ready  <= 1'b1;
          hmem_req   <= 1'b0;
          hmem_we    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  cache_perf_counter #(.WIDTH(PERF_CNT_W)) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ctl.count_hit),
    .count   (hit_count)
  );

  cache_perf_counter #(.WIDTH(PERF_CNT_W)) u_miss_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ctl.count_miss),
    .count   (miss_count)
  );

  // the victim-tag strobe fires exactly once per EVICT entry
  cache_perf_counter #(.WIDTH(PERF_CNT_W)) u_evict_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ctl.use_victim_tag_for_hmem_block_address),
    .count   (evict_count)
  );
`else
  assign hit_count   = '0;
  assign miss_count  = '0;
  assign evict_count = '0;
`endif

endmodule

// File: tb/tb_cache_seq_controller.sv
module tb_cache_seq_controller;
  import cache_ctrl_pkg::*;

  localparam int NI = 4;
  localparam int LW_TAB [NI] = '{4, 8, 4, 1};
  localparam int WB_TAB [NI] = '{1, 1, 0, 1};

  localparam int E_WB = 0, E_RB = 1, E_INST = 2, E_RESP = 3, E_PW = 4, E_SD = 5;
  localparam int E_HIT = 6, E_MISS = 7, E_RD = 8, E_WR = 9, E_EVI = 10, E_HREQ = 11;
  localparam int E_LRU = 12, E_SHBA = 13, E_CLRV = 14, E_CLRD = 15, E_RSTC = 16;
  localparam int E_MRMBAD = 17, E_DEC = 18;
  localparam int NEV = 19;

  string ev_name [NEV] = '{"wr_beats", "rd_beats", "installs", "resp", "perform_write",
                           "set_dirty", "count_hit", "count_miss", "count_read",
                           "count_write", "evict_entry", "hmem_req_cycles", "lru",
                           "set_hmem_addr", "clr_valid", "clr_dirty", "reset_counter",
                           "mrm_without_req", "decrements"};

  logic clk;
  logic reset_n;
  logic [NI-1:0] req_valid, req_we, req_ready, resp_valid, hmem_req, hmem_we;
  logic [NI-1:0] pre_valid, pre_dirty, preset;
  logic [PERF_CNT_W-1:0] hit_cnt [NI];
  logic [PERF_CNT_W-1:0] miss_cnt [NI];
  logic [PERF_CNT_W-1:0] evict_cnt [NI];
  bit spur_en;
  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int tot_hit [NI];
  int tot_miss [NI];
  int tot_evi [NI];
  logic sat_inc;
  logic [2:0] sat_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LW = LW_TAB[g];
    cache_internal_if ctl_if ();
    logic mem_ack = 1'b0;
    logic line_valid = 1'b0;
    logic line_dirty = 1'b0;
    int cnt = 0;
    int ev [NEV];

    cache_seq_controller #(.LINE_WORDS(LW), .WRITE_BACK(WB_TAB[g])) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_we      (req_we[g]),
      .resp_valid  (resp_valid[g]),
      .hmem_req    (hmem_req[g]),
      .hmem_we     (hmem_we[g]),
      .hmem_ack    (mem_ack),
      .ctl         (ctl_if),
      .hit_count   (hit_cnt[g]),
      .miss_count  (miss_cnt[g]),
      .evict_count (evict_cnt[g])
    );

    // single-line datapath stand-in; status reflects strobes of this cycle
    always @(posedge clk) begin
      if (preset[g]) begin
        line_valid <= pre_valid[g];
        line_dirty <= pre_dirty[g];
      end else begin
        if (ctl_if.clear_selected_valid_bit) line_valid <= 1'b0;
        if (ctl_if.finish_new_line_install)  line_valid <= 1'b1;
        if (ctl_if.set_selected_dirty_bit)   line_dirty <= 1'b1;
        if (ctl_if.clear_selected_dirty_bit) line_dirty <= 1'b0;
      end
      if (ctl_if.reset_counter) cnt <= LW - 1;
      else if (ctl_if.decrement_counter) cnt <= cnt - 1;
    end
    assign ctl_if.valid_block_match = line_valid | ctl_if.finish_new_line_install;
    assign ctl_if.valid_dirty_bit   = line_dirty;
    assign ctl_if.counter_done = ctl_if.reset_counter ? (LW == 1) :
                                 ctl_if.decrement_counter ? (cnt == 1) : (cnt == 0);

    // higher memory: random ack latency, occasional stray acks when idle
    always @(posedge clk) begin
      #1;
      if (hmem_req[g]) mem_ack <= ($urandom_range(0, 2) != 0);
      else             mem_ack <= spur_en && ($urandom_range(0, 3) == 0);
    end

    always @(negedge clk) begin
      if (hmem_req[g] && mem_ack) begin
        if (hmem_we[g]) ev[E_WB] <= ev[E_WB] + 1;
        else            ev[E_RB] <= ev[E_RB] + 1;
      end
      if (ctl_if.finish_new_line_install) ev[E_INST] <= ev[E_INST] + 1;
      if (resp_valid[g])                  ev[E_RESP] <= ev[E_RESP] + 1;
      if (ctl_if.perform_write)           ev[E_PW]   <= ev[E_PW] + 1;
      if (ctl_if.set_selected_dirty_bit)  ev[E_SD]   <= ev[E_SD] + 1;
      if (ctl_if.count_hit)               ev[E_HIT]  <= ev[E_HIT] + 1;
      if (ctl_if.count_miss)              ev[E_MISS] <= ev[E_MISS] + 1;
      if (ctl_if.count_read)              ev[E_RD]   <= ev[E_RD] + 1;
      if (ctl_if.count_write)             ev[E_WR]   <= ev[E_WR] + 1;
      if (ctl_if.use_victim_tag_for_hmem_block_address) ev[E_EVI] <= ev[E_EVI] + 1;
      if (hmem_req[g])                    ev[E_HREQ] <= ev[E_HREQ] + 1;
      if (ctl_if.process_lru_counters)    ev[E_LRU]  <= ev[E_LRU] + 1;
      if (ctl_if.set_hmem_block_address)  ev[E_SHBA] <= ev[E_SHBA] + 1;
      if (ctl_if.clear_selected_valid_bit) ev[E_CLRV] <= ev[E_CLRV] + 1;
      if (ctl_if.clear_selected_dirty_bit) ev[E_CLRD] <= ev[E_CLRD] + 1;
      if (ctl_if.reset_counter)           ev[E_RSTC] <= ev[E_RSTC] + 1;
      if (ctl_if.miss_recovery_mode && !hmem_req[g]) ev[E_MRMBAD] <= ev[E_MRMBAD] + 1;
      if (ctl_if.decrement_counter)       ev[E_DEC]  <= ev[E_DEC] + 1;
    end
  end

  cache_perf_counter #(.WIDTH(3)) u_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sat_inc),
    .count   (sat_cnt)
  );

  function automatic int ev_get(input int k, input int e);
    case (k)
      0:       return g_dut[0].ev[e];
      1:       return g_dut[1].ev[e];
      2:       return g_dut[2].ev[e];
      default: return g_dut[3].ev[e];
    endcase
  endfunction

  function automatic logic ctl_any_strobe(input int k);
    case (k)
      0:       return g_dut[0].ctl_if.reset_counter | g_dut[0].ctl_if.miss_recovery_mode |
                      g_dut[0].ctl_if.count_read | g_dut[0].ctl_if.perform_write;
      1:       return g_dut[1].ctl_if.reset_counter | g_dut[1].ctl_if.miss_recovery_mode |
                      g_dut[1].ctl_if.count_read | g_dut[1].ctl_if.perform_write;
      2:       return g_dut[2].ctl_if.reset_counter | g_dut[2].ctl_if.miss_recovery_mode |
                      g_dut[2].ctl_if.count_read | g_dut[2].ctl_if.perform_write;
      default: return g_dut[3].ctl_if.reset_counter | g_dut[3].ctl_if.miss_recovery_mode |
                      g_dut[3].ctl_if.count_read | g_dut[3].ctl_if.perform_write;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_perf(input int k);
`ifdef CACHE_CTRL_PERF_EN
    check($sformatf("k%0d.hit_count", k),   hit_cnt[k],   tot_hit[k]);
    check($sformatf("k%0d.miss_count", k),  miss_cnt[k],  tot_miss[k]);
    check($sformatf("k%0d.evict_count", k), evict_cnt[k], tot_evi[k]);
`else
    check($sformatf("k%0d.hit_count", k),   hit_cnt[k],   32'd0);
    check($sformatf("k%0d.miss_count", k),  miss_cnt[k],  32'd0);
    check($sformatf("k%0d.evict_count", k), evict_cnt[k], 32'd0);
`endif
  endtask

  // one request: cache state chosen up front, outcome predicted from the rules
  task automatic do_req(input int k, input bit we, input bit hit, input bit dirty);
    int  base [NEV];
    int  exp [NEV];
    int  lw, c0, lat, ready_err;
    bit  wb, fill, evict, wt, got;
    lw = LW_TAB[k];
    wb = (WB_TAB[k] != 0);
    @(negedge clk);
    pre_valid[k] = hit; pre_dirty[k] = dirty; preset[k] = 1'b1;
    @(negedge clk);
    preset[k] = 1'b0;
    @(negedge clk);
    for (int e = 0; e < NEV; e++) base[e] = ev_get(k, e);
    check($sformatf("k%0d.ready_idle", k), req_ready[k], 1'b1);
    req_valid[k] = 1'b1; req_we[k] = we; c0 = cyc;
    got = 0; lat = 0; ready_err = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (resp_valid[k]) begin got = 1; lat = cyc - c0; break; end
      if (req_ready[k]) ready_err++;
      req_valid[k] = 1'($urandom_range(0, 1));
      req_we[k]    = 1'($urandom_range(0, 1));
    end
    req_valid[k] = 1'b0;
    check($sformatf("k%0d.resp_seen", k), got, 1'b1);
    check($sformatf("k%0d.ready_low_busy", k), ready_err, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;

    fill  = !hit && !(we && !wb);
    evict = fill && wb && dirty;
    wt    = we && !wb;
    exp[E_WB]     = (evict ? lw : 0) + (wt ? 1 : 0);
    exp[E_RB]     = fill ? lw : 0;
    exp[E_INST]   = int'(fill);
    exp[E_RESP]   = 1;
    exp[E_PW]     = int'(we && (hit || fill));
    exp[E_SD]     = int'(we && wb && (hit || fill));
    exp[E_HIT]    = int'(hit || fill);
    exp[E_MISS]   = int'(!hit);
    exp[E_RD]     = int'(!we);
    exp[E_WR]     = int'(we);
    exp[E_EVI]    = int'(evict);
    exp[E_HREQ]   = 0;
    exp[E_LRU]    = int'(hit || fill);
    exp[E_SHBA]   = fill ? (evict ? 2 : 1) : 0;
    exp[E_CLRV]   = int'(fill && !evict);
    exp[E_CLRD]   = int'(evict);
    exp[E_RSTC]   = fill ? (evict ? 2 : 1) : 0;
    exp[E_MRMBAD] = 0;
    exp[E_DEC]    = (evict ? lw : 0) + (fill ? lw : 0);
    for (int e = 0; e < NEV; e++) begin
      if (e == E_HREQ && !(hit && !we)) continue;
      check($sformatf("k%0d.we%0d.hit%0d.d%0d.%s", k, we, hit, dirty, ev_name[e]),
            ev_get(k, e) - base[e], exp[e]);
    end
    if (hit && !we) check($sformatf("k%0d.read_hit_latency", k), lat, 2);
    tot_hit[k]  += exp[E_HIT];
    tot_miss[k] += exp[E_MISS];
    tot_evi[k]  += exp[E_EVI];
    check_perf(k);
  endtask

  initial begin
    int rb0;
    bit got;
    reset_n = 1'b0;
    req_valid = '0; req_we = '0; pre_valid = '0; pre_dirty = '0; preset = '0;
    spur_en = 1'b0; sat_inc = 1'b0;
    for (int k = 0; k < NI; k++) begin tot_hit[k] = 0; tot_miss[k] = 0; tot_evi[k] = 0; end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst.k%0d.req_ready", k), req_ready[k], 1'b1);
      check($sformatf("rst.k%0d.resp_valid", k), resp_valid[k], 1'b0);
      check($sformatf("rst.k%0d.hmem_req", k), hmem_req[k], 1'b0);
      check($sformatf("rst.k%0d.hmem_we", k), hmem_we[k], 1'b0);
      check($sformatf("rst.k%0d.ctl_strobes", k), ctl_any_strobe(k), 1'b0);
      check_perf(k);
    end
    check("rst.sat_cnt", sat_cnt, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(0, 1'b0, 1'b1, 1'b0);  // read hit, LINE_WORDS=4
    do_req(0, 1'b0, 1'b0, 1'b0);  // read miss, clean victim
    do_req(1, 1'b1, 1'b0, 1'b1);  // write miss, dirty victim, LINE_WORDS=8
    do_req(2, 1'b1, 1'b0, 1'b0);  // write miss, write-through
    do_req(2, 1'b1, 1'b1, 1'b0);  // write hit, write-through
    do_req(2, 1'b0, 1'b0, 1'b0);  // read miss, write-through config
    do_req(3, 1'b0, 1'b0, 1'b1);  // LINE_WORDS=1 dirty read miss
    do_req(0, 1'b1, 1'b1, 1'b0);  // write hit, write-back

    // reset in the middle of a fill
    @(negedge clk);
    pre_valid[0] = 1'b0; pre_dirty[0] = 1'b0; preset[0] = 1'b1;
    @(negedge clk);
    preset[0] = 1'b0;
    rb0 = ev_get(0, E_RB);
    req_valid[0] = 1'b1; req_we[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (ev_get(0, E_RB) - rb0 >= 2) begin got = 1; break; end
    end
    check("midfill.two_beats_reached", got, 1'b1);
    check("midfill.req_before_reset", hmem_req[0], 1'b1);
    reset_n = 1'b0;
    #1;
    check("midfill.hmem_req_low", hmem_req[0], 1'b0);
    check("midfill.req_ready_high", req_ready[0], 1'b1);
    check("midfill.ctl_quiet", ctl_any_strobe(0), 1'b0);
    check("midfill.beats_at_reset", ev_get(0, E_RB) - rb0, 2);
    for (int k = 0; k < NI; k++) begin tot_hit[k] = 0; tot_miss[k] = 0; tot_evi[k] = 0; end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_perf(0);
    do_req(0, 1'b0, 1'b0, 1'b0);  // restarts with a full 4-beat fill

    // ten hits
    for (int i = 0; i < 10; i++) do_req(0, 1'b0, 1'b1, 1'b0);

    // saturation of a narrow counter instance
    @(negedge clk); sat_inc = 1'b1;
    repeat (5) @(negedge clk);
    check("sat.after5", sat_cnt, 3'd5);
    repeat (5) @(negedge clk);
    check("sat.after10", sat_cnt, 3'd7);
    sat_inc = 1'b0;

    // randomized traffic with stray acks enabled
    spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_req($urandom_range(0, NI - 1), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    spur_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
